// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID instruction queue.
// The slave modport is the queue's view; the master modport is the pipeline side.
interface if_id_queue_if #(
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          flush_i;
  logic          valid_i;
  logic          ready_o;
  logic [63:0]   pc_i;
  logic [31:0]   instr_i;
  logic          valid_o;
  logic          ready_i;
  logic [63:0]   pc_o;
  logic [31:0]   instr_o;
  logic [CW-1:0] count_o;

  modport master (
    output flush_i, valid_i, pc_i, instr_i, ready_i,
    input  ready_o, valid_o, pc_o, instr_o, count_o
  );

  modport slave (
    input  flush_i, valid_i, pc_i, instr_i, ready_i,
    output ready_o, valid_o, pc_o, instr_o, count_o
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: small FIFO of {pc, instr} pairs between fetch and
// decode. Presents a NOP with valid low when empty or while flushing.
module if_id_queue #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  if_id_queue_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [63:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_ready;
  logic w_valid;
  logic w_push;
  logic w_pop;

  // Handshake qualifiers derived from occupancy only (no ready_i -> ready_o path)
  always_comb begin
    w_ready = (r_count != FULL_CNT);
    w_valid = (r_count != '0) & ~bus.flush_i;
    w_push  = bus.valid_i & w_ready;
    w_pop   = w_valid & bus.ready_i;
  end

  // Drive decode side: head entry when valid, otherwise zero PC and NOP
  always_comb begin
    bus.ready_o = w_ready;
    bus.valid_o = w_valid;
    bus.count_o = r_count;
    bus.pc_o    = '0;
    bus.instr_o = NOP_INSTR;
    if (w_valid) begin
      bus.pc_o    = r_pc_mem[r_rd_ptr];
      bus.instr_o = r_instr_mem[r_rd_ptr];
    end
  end

  // Entry storage; written on an accepted push, never on a flush cycle
  always_ff @(posedge clk_i) begin
    if (w_push && !bus.flush_i) begin
      r_pc_mem[r_wr_ptr]    <= bus.pc_i;
      r_instr_mem[r_wr_ptr] <= bus.instr_i;
    end
  end

  // Pointer and occupancy update; flush overrides push and pop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_count <= FULL_CNT);
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_push && (r_count == FULL_CNT)));
`endif
endmodule
